key_debounce_pulse: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 18 +
 rtl/key_debounce_chan.sv | 91 +++++++++
 rtl/key_debounce_pulse.sv | 33 +++
 tb/tb_key_debounce_pulse.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding, key polarity constants and counter sizing for the key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    localparam logic KEY_PRESSED  = 1'b1;
    localparam logic KEY_RELEASED = 1'b0;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key channel: synchroniser, stability filter FSM, registered level and strobes.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat press strobes.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debounce_chan: illegal parameter values");
    end

    logic [1:0]    sync;
    logic          s;
    key_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          level_d, press_d, release_d, accept, rep_fire;

    assign s      = sync[1];
    assign accept = (state == PRESS_WAIT) && (state_d == HELD);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync          <= {KEY_RELEASED, KEY_RELEASED};
            state         <= IDLE;
            cnt           <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[0], ~key_n};
            state         <= state_d;
            cnt           <= cnt_d;
            key_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // The counter only advances while waiting in place, so every state entry starts it at zero.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:         state_d = (s == KEY_PRESSED) ? PRESS_WAIT : IDLE;
            PRESS_WAIT:   state_d = (s == KEY_RELEASED) ? IDLE : (cnt == CNT_LAST) ? HELD : PRESS_WAIT;
            HELD:         state_d = (s == KEY_RELEASED) ? RELEASE_WAIT : HELD;
            RELEASE_WAIT: state_d = (s == KEY_PRESSED) ? HELD : (cnt == CNT_LAST) ? IDLE : RELEASE_WAIT;
        endcase
        cnt_d = ((state_d == state) && (state == PRESS_WAIT || state == RELEASE_WAIT)) ? cnt + 1'b1 : '0;
    end

    always_comb begin
        level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
        press_d   = accept || rep_fire;
        release_d = (state == RELEASE_WAIT) && (state_d == IDLE);
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = cnt_width(RMAX);

    logic [RCW-1:0] rep_cnt;

    // Counts down to the next repeat; only cycles spent in HELD move it, so RELEASE_WAIT freezes it.
    always_ff @(posedge clk) begin
        if (reset)
            rep_cnt <= '0;
        else if (accept)
            rep_cnt <= RCW'(REPEAT_DELAY - 1);
        else if (state == HELD)
            rep_cnt <= rep_fire ? RCW'(REPEAT_PERIOD - 1) : rep_cnt - 1'b1;
    end

    assign rep_fire = (state == HELD) && (rep_cnt == '0);
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: debounces NUM_KEYS active-low pushbuttons into levels and single-cycle strobes.
// Define KEY_AUTOREPEAT_EN to enable hold-to-repeat press strobes.
module key_debounce_pulse #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    genvar i;
    for (i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .key_n        (key_n[i]),
            .key_level    (key_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: directed bench with a run-length reference model checked every cycle.
module tb_key_debounce_pulse;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] key_n = '1;
    logic [N-1:0] key_level, press_pulse, release_pulse;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    key_debounce_pulse #(
        .NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n),
        .key_level(key_level), .press_pulse(press_pulse), .release_pulse(release_pulse)
    );

    always @(posedge clk) edge_n++;

    // Reference: a level flips after D+1 consecutive synchronised samples that disagree with it.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_pp, m_rp;
    int           run[N];
    int           held_n[N];
    logic         ms, was_held;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pp[i] = 0; m_rp[i] = 0;
                run[i] = 0; held_n[i] = 0;
            end else begin
                ms = m_s2[i];
                was_held = m_lvl[i] && run[i] == 0;
                m_pp[i] = 0;
                m_rp[i] = 0;
                if (ms != m_lvl[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        m_lvl[i] = ms;
                        run[i] = 0;
                        held_n[i] = 0;
                        if (ms) m_pp[i] = 1; else m_rp[i] = 1;
                    end
                end else begin
                    run[i] = 0;
                end
                if (was_held) held_n[i]++;
`ifdef KEY_AUTOREPEAT_EN
                if (was_held && (held_n[i] == RD || (held_n[i] > RD && (held_n[i] - RD) % RP == 0)))
                    m_pp[i] = 1;
`endif
                m_s2[i] = m_s1[i];
                m_s1[i] = ~key_n[i];
            end
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            checks += 3;
            if (key_level !== m_lvl) begin
                failures++;
                $display("FAIL level edge=%0d actual=%b expected=%b", edge_n, key_level, m_lvl);
            end
            if (press_pulse !== m_pp) begin
                failures++;
                $display("FAIL press edge=%0d actual=%b expected=%b", edge_n, press_pulse, m_pp);
            end
            if (release_pulse !== m_rp) begin
                failures++;
                $display("FAIL release edge=%0d actual=%b expected=%b", edge_n, release_pulse, m_rp);
            end
        end
    end

    int pcount[N], rcount[N], plast[N], rlast[N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (press_pulse[i] === 1'b1) begin pcount[i]++; plast[i] = edge_n; end
            if (release_pulse[i] === 1'b1) begin rcount[i]++; rlast[i] = edge_n; end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int d, r, p0;
        for (int i = 0; i < N; i++) begin pcount[i] = 0; rcount[i] = 0; plast[i] = 0; rlast[i] = 0; end
        cyc(3);
        chk("reset_level", int'(key_level), 0);
        chk("reset_press", int'(press_pulse), 0);
        chk("reset_release", int'(release_pulse), 0);
        reset = 0;
        cyc(50);
        chk("idle_pulses", pcount[0] + pcount[1] + pcount[2] + pcount[3] + rcount[0] + rcount[1] + rcount[2] + rcount[3], 0);

        key_n[0] = 0; d = edge_n + 1;
        cyc(15);
        chk("press0_latency", plast[0] - d, 10);
        chk("press0_count", pcount[0], 1);
        chk("press0_level", int'(key_level[0]), 1);

        for (int c = 0; c < 40; c++) begin
            key_n[1] = ((c / 3) % 2) != 0;
            cyc(1);
        end
        key_n[1] = 1;
        cyc(20);
        chk("bounce1_press", pcount[1], 0);
        chk("bounce1_release", rcount[1], 0);
        chk("bounce1_level", int'(key_level[1]), 0);

        p0 = pcount[0];
        key_n[0] = 1; cyc(3);
        key_n[0] = 0; cyc(4);
        key_n[0] = 1; r = edge_n + 1;
        cyc(15);
        chk("release0_latency", rlast[0] - r, 10);
        chk("release0_count", rcount[0], 1);
        chk("release0_level", int'(key_level[0]), 0);
`ifndef KEY_AUTOREPEAT_EN
        chk("release0_no_press", pcount[0] - p0, 0);
`endif

        key_n[1:0] = 2'b00; d = edge_n + 1;
        cyc(15);
        chk("simul_press_same", plast[1], plast[0]);
        chk("simul_press_latency", plast[1] - d, 10);
        key_n[1:0] = 2'b11; d = edge_n + 1;
        cyc(15);
        chk("simul_release_same", rlast[1], rlast[0]);
        chk("simul_release_latency", rlast[0] - d, 10);

        key_n[2] = 0;
        cyc(7);
        reset = 1; r = edge_n + 1;
        cyc(1);
        reset = 0;
        chk("midreset_level", int'(key_level), 0);
        chk("midreset_press", int'(press_pulse), 0);
        chk("midreset_press2_none", pcount[2], 0);
        cyc(15);
        chk("midreset_latency", plast[2] - r, 11);
        chk("midreset_count", pcount[2], 1);
        key_n[2] = 1;
        cyc(15);
        chk("midreset_release", rcount[2], 1);

        key_n[3] = 0; d = edge_n + 1;
        cyc(65);
        key_n[3] = 1;
        cyc(15);
`ifdef KEY_AUTOREPEAT_EN
        chk("hold3_press_count", pcount[3], 5);
        chk("hold3_last_press", plast[3] - d, 60);
`else
        chk("hold3_press_count", pcount[3], 1);
        chk("hold3_last_press", plast[3] - d, 10);
`endif
        chk("hold3_release", rcount[3], 1);
        chk("final_level", int'(key_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
